segment_if_id_skid: RTL and testbench

Parametrised successor to the IF/ID segment register. It carries {pc, instruction} from fetch to decode using a valid/ready handshake with a 2-entry skid buffer, so a decode stall never drops a fetched instruction, and in_ready is driven from registered state. It adds a synchronous flush that inserts an all-zero bubble, and a saturating stall-cycle counter. Instruction fields for decode are sliced from the output register.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/segment_field_split.sv | 26 ++
 rtl/segment_if_id_skid.sv | 141 ++++++++++++++
 tb/tb_segment_if_id_skid.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the pipeline segment registers: instruction field
// bit positions, the NOP bubble encoding and the default {pc, instr} payload.
package seg_pkg;

    localparam int F31_30_HI = 31;
    localparam int F31_30_LO = 30;
    localparam int F29_28_HI = 29;
    localparam int F29_28_LO = 28;
    localparam int F27_HI    = 27;
    localparam int F27_LO    = 27;
    localparam int F26_HI    = 26;
    localparam int F26_LO    = 26;
    localparam int F25_22_HI = 25;
    localparam int F25_22_LO = 22;
    localparam int F21_18_HI = 21;
    localparam int F21_18_LO = 18;
    localparam int F17_14_HI = 17;
    localparam int F17_14_LO = 14;
    localparam int F25_0_HI  = 25;
    localparam int F25_0_LO  = 0;

    localparam int IF_ID_PC_W   = 32;
    localparam int IF_ID_DATA_W = 32;

    localparam logic [IF_ID_DATA_W-1:0] NOP_INSTR = '0;

    // Default-width payload; parametrised instances build the same layout locally.
    typedef struct packed {
        logic [IF_ID_PC_W-1:0]   pc;
        logic [IF_ID_DATA_W-1:0] instr;
    } if_id_payload_t;

endpackage

// File: rtl/segment_field_split.sv
// Combinational slicer from the low 32 instruction bits to the decode fields;
// shared by the IF/ID and ID/EX segments.
module segment_field_split
    import seg_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [1:0]  f_31_30_o,
    output logic [1:0]  f_29_28_o,
    output logic        f_27_o,
    output logic        f_26_o,
    output logic [3:0]  f_25_22_o,
    output logic [3:0]  f_21_18_o,
    output logic [3:0]  f_17_14_o,
    output logic [25:0] f_25_0_o
);

    assign f_31_30_o = instr_i[F31_30_HI:F31_30_LO];
    assign f_29_28_o = instr_i[F29_28_HI:F29_28_LO];
    assign f_27_o    = instr_i[F27_HI];
    assign f_26_o    = instr_i[F26_HI];
    assign f_25_22_o = instr_i[F25_22_HI:F25_22_LO];
    assign f_21_18_o = instr_i[F21_18_HI:F21_18_LO];
    assign f_17_14_o = instr_i[F17_14_HI:F17_14_LO];
    assign f_25_0_o  = instr_i[F25_0_HI:F25_0_LO];

endmodule

// File: rtl/segment_if_id_skid.sv
// IF/ID segment register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush to an all-zero bubble and a saturating stall counter.
module segment_if_id_skid
    import seg_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [1:0]        f_31_30,
    output logic [1:0]        f_29_28,
    output logic              f_27,
    output logic              f_26,
    output logic [3:0]        f_25_22,
    output logic [3:0]        f_21_18,
    output logic [3:0]        f_17_14,
    output logic [25:0]       f_25_0,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
    } payload_t;

    payload_t         m_q, m_d, s_q, s_d, in_s;
    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire_s, out_fire_s;

    assign in_s.pc    = in_pc;
    assign in_s.instr = in_instr;

    // With the skid buffer in_ready depends on registered state only.
    assign in_ready   = (SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = m_valid_q && out_ready;

    assign out_valid  = m_valid_q;
    assign out_pc     = m_q.pc;
    assign out_instr  = m_q.instr;
    assign stall_cnt  = cnt_q;

    // Next-state for main/skid entries: flush, then skid drain, then new input.
    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_d.pc    = {PC_W{1'b0}};
            m_d.instr = DATA_W'(NOP_INSTR);
            s_d.pc    = {PC_W{1'b0}};
            s_d.instr = DATA_W'(NOP_INSTR);
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!m_valid_q || out_ready) begin
                if (s_valid_q) begin
                    m_d       = s_q;
                    m_valid_d = 1'b1;
                    s_valid_d = 1'b0;
                end else begin
                    m_valid_d = in_fire_s;
                    if (in_fire_s) begin
                        m_d = in_s;
                    end else begin
                        m_d = m_q;
                    end
                end
            end else if (in_fire_s) begin
                s_d       = in_s;
                s_valid_d = 1'b1;
            end else begin
                s_d = s_q;
            end
        end else begin
            if (in_fire_s) begin
                m_d       = in_s;
                m_valid_d = 1'b1;
            end else if (out_fire_s) begin
                m_valid_d = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
        end
    end

    // Stall counter saturates at all-ones; flush does not touch it.
    always_comb begin
        cnt_d = cnt_q;
        if (m_valid_q && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Segment state updates on the falling edge like the other segment registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    segment_field_split u_split (
        .instr_i   (m_q.instr[31:0]),
        .f_31_30_o (f_31_30),
        .f_29_28_o (f_29_28),
        .f_27_o    (f_27),
        .f_26_o    (f_26),
        .f_25_22_o (f_25_22),
        .f_21_18_o (f_21_18),
        .f_17_14_o (f_17_14),
        .f_25_0_o  (f_25_0)
    );

endmodule

// File: tb/tb_segment_if_id_skid.sv
// Scoreboard bench for segment_if_id_skid: a skid build (CNT_W=4) and a
// non-skid build, each with its own expected-output queue and monitor.
module tb_segment_if_id_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Skid build
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
    logic [1:0]  a_f3130, a_f2928;
    logic        a_f27, a_f26;
    logic [3:0]  a_f2522, a_f2118, a_f1714;
    logic [25:0] a_f250;
    logic [3:0]  a_cnt;

    // Non-skid build
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
    logic [1:0]  b_f3130, b_f2928;
    logic        b_f27, b_f26;
    logic [3:0]  b_f2522, b_f2118, b_f1714;
    logic [25:0] b_f250;
    logic [15:0] b_cnt;

    segment_if_id_skid #(.PC_W(32), .DATA_W(32), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_instr(a_in_instr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
        .f_31_30(a_f3130), .f_29_28(a_f2928), .f_27(a_f27), .f_26(a_f26),
        .f_25_22(a_f2522), .f_21_18(a_f2118), .f_17_14(a_f1714), .f_25_0(a_f250),
        .stall_cnt(a_cnt)
    );

    segment_if_id_skid #(.PC_W(32), .DATA_W(32), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
        .f_31_30(b_f3130), .f_29_28(b_f2928), .f_27(b_f27), .f_26(b_f26),
        .f_25_22(b_f2522), .f_21_18(b_f2118), .f_17_14(b_f1714), .f_25_0(b_f250),
        .stall_cnt(b_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] a_q[$];
    logic [63:0] b_q[$];
    logic [63:0] a_exp, b_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return (pc == 32'd0) ? 32'hA5C3_8001 : (32'hA000_0000 | pc);
    endfunction

    // Monitors: every consumed output must be the oldest expected entry.
    always @(posedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                chk("a_sb_unexpected_out", {a_out_pc, a_out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                a_exp = a_q.pop_front();
                chk("a_sb_out", {a_out_pc, a_out_instr}, a_exp);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                chk("b_sb_unexpected_out", {b_out_pc, b_out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                b_exp = b_q.pop_front();
                chk("b_sb_out", {b_out_pc, b_out_instr}, b_exp);
            end
        end
    end

    // One cycle of stimulus on the skid build; expectations are queued on acceptance.
    task automatic a_drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        a_in_valid = v; a_in_pc = pc; a_in_instr = ins(pc); a_out_ready = rdy; a_flush = fl;
        @(posedge clk);
        if (fl) a_q.delete();
        else if (v && a_in_ready) a_q.push_back({pc, ins(pc)});
        @(negedge clk); #1;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        b_in_valid = v; b_in_pc = pc; b_in_instr = ins(pc); b_out_ready = rdy; b_flush = fl;
        @(posedge clk);
        if (fl) b_q.delete();
        else if (v && b_in_ready) b_q.push_back({pc, ins(pc)});
        @(negedge clk); #1;
    endtask

    initial begin
        // Reset with an input offered: outputs clear before any clock edge
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_pc = 32'h44; a_in_instr = 32'hDEAD_BEEF; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_pc = 32'h0;  b_in_instr = 32'h0;         b_out_ready = 1'b1;
        #3;
        chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_out_pc", {32'd0, a_out_pc}, 64'd0);
        chk("rst_out_instr", {32'd0, a_out_instr}, 64'd0);
        chk("rst_stall_cnt", {60'd0, a_cnt}, 64'd0);
        chk("rst_f25_0", {38'd0, a_f250}, 64'd0);
        a_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;

        // Streaming: one output per edge, 1-edge latency
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
            chk("stream_valid", {63'd0, a_out_valid}, 64'd1);
            chk("stream_pc", {32'd0, a_out_pc}, 64'(4 * i));
            if (i == 0) begin
                chk("f_31_30", {62'd0, a_f3130}, 64'd2);
                chk("f_29_28", {62'd0, a_f2928}, 64'd2);
                chk("f_27", {63'd0, a_f27}, 64'd0);
                chk("f_26", {63'd0, a_f26}, 64'd1);
                chk("f_25_22", {60'd0, a_f2522}, 64'd7);
                chk("f_21_18", {60'd0, a_f2118}, 64'd0);
                chk("f_17_14", {60'd0, a_f1714}, 64'd14);
                chk("f_25_0", {38'd0, a_f250}, 64'h1C3_8001);
            end
        end
        a_drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drain_valid", {63'd0, a_out_valid}, 64'd0);

        // Stall: pc 4 in main, pc 8 captured in skid
        a_drive(1'b1, 32'd4, 1'b1, 1'b0);
        a_drive(1'b1, 32'd8, 1'b0, 1'b0);
        a_drive(1'b1, 32'd12, 1'b0, 1'b0);
        a_drive(1'b1, 32'd12, 1'b0, 1'b0);
        chk("stall_in_ready", {63'd0, a_in_ready}, 64'd0);
        chk("stall_cnt3", {60'd0, a_cnt}, 64'd3);
        chk("stall_pc", {32'd0, a_out_pc}, 64'd4);
        a_drive(1'b1, 32'd12, 1'b1, 1'b0);
        chk("skid_drain_pc", {32'd0, a_out_pc}, 64'd8);
        chk("skid_drain_ready", {63'd0, a_in_ready}, 64'd1);
        a_drive(1'b1, 32'd12, 1'b1, 1'b0);
        chk("after_skid_pc", {32'd0, a_out_pc}, 64'd12);

        // Flush with skid full; the offered pc 20 must never appear
        a_drive(1'b1, 32'd16, 1'b0, 1'b0);
        chk("skid_full_ready", {63'd0, a_in_ready}, 64'd0);
        a_drive(1'b1, 32'd20, 1'b0, 1'b1);
        chk("flush_valid", {63'd0, a_out_valid}, 64'd0);
        chk("flush_instr", {32'd0, a_out_instr}, 64'd0);
        chk("flush_pc", {32'd0, a_out_pc}, 64'd0);
        chk("flush_ready", {63'd0, a_in_ready}, 64'd1);
        chk("flush_cnt", {60'd0, a_cnt}, 64'd4);
        a_drive(1'b0, 32'd0, 1'b1, 1'b0);
        a_drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("post_flush_valid", {63'd0, a_out_valid}, 64'd0);
        a_drive(1'b1, 32'd24, 1'b1, 1'b0);
        a_drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Reset mid-transfer loses the in-flight instruction
        a_drive(1'b1, 32'd28, 1'b1, 1'b0);
        rst = 1'b1;
        a_q.delete();
        #1;
        chk("midrst_valid", {63'd0, a_out_valid}, 64'd0);
        chk("midrst_ready", {63'd0, a_in_ready}, 64'd1);
        chk("midrst_cnt", {60'd0, a_cnt}, 64'd0);
        a_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;

        // Saturation of the 4-bit stall counter
        a_drive(1'b1, 32'h40, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            a_drive(1'b0, 32'd0, 1'b0, 1'b0);
            if (k == 14) chk("sat_cnt14", {60'd0, a_cnt}, 64'd14);
            if (k == 15) chk("sat_cnt15", {60'd0, a_cnt}, 64'd15);
        end
        chk("sat_cnt20", {60'd0, a_cnt}, 64'd15);
        a_drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Non-skid build: ready drops combinationally while main is stalled
        b_drive(1'b1, 32'd4, 1'b1, 1'b0);
        chk("b_pc4", {32'd0, b_out_pc}, 64'd4);
        for (int k = 0; k < 3; k++) begin
            b_drive(1'b1, 32'd8, 1'b0, 1'b0);
            chk("b_stall_ready", {63'd0, b_in_ready}, 64'd0);
        end
        chk("b_stall_cnt", {48'd0, b_cnt}, 64'd3);
        chk("b_stall_pc", {32'd0, b_out_pc}, 64'd4);
        b_drive(1'b1, 32'd8, 1'b1, 1'b0);
        chk("b_pc8", {32'd0, b_out_pc}, 64'd8);
        b_drive(1'b1, 32'd12, 1'b1, 1'b0);
        chk("b_pc12", {32'd0, b_out_pc}, 64'd12);
        b_drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("b_drain_valid", {63'd0, b_out_valid}, 64'd0);

        @(negedge clk); #1;
        chk("a_sb_empty", 64'(a_q.size()), 64'd0);
        chk("b_sb_empty", 64'(b_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
